demux_1_2_filas: RTL
====================

DEMUX_1_2_FILAS -- requirements
Module: demux_1_2_filas

Interface
REQ-001 The block SHALL have parameter BITS_DATOS, default 8: pixel data width.
REQ-002 The block SHALL have parameter ANCHO_FILA, default 640: pixels per row; legal range 2..1024.
REQ-003 The block SHALL have parameter BITS_DIR, default 10: column address width; ANCHO_FILA <= 2**BITS_DIR.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port entrada, input, BITS_DATOS bits: incoming pixel.
REQ-007 The block SHALL have port entrada_valida, input, 1 bit: entrada is valid this cycle.
REQ-008 The block SHALL have ports salida_1 and salida_2, output, BITS_DATOS bits each: write data to row buffer 1 and row buffer 2.
REQ-009 The block SHALL have ports escritura_1 and escritura_2, output, 1 bit each: write enables for row buffer 1 and row buffer 2.
REQ-010 The block SHALL have port direccion, output, BITS_DIR bits: shared column write address.
REQ-011 The block SHALL have port seleccion, output, 1 bit: the buffer holding the last complete row (0 = buffer 1, 1 = buffer 2). It drives the read-side 2:1 mux select.
REQ-012 The block SHALL have port fila_lista, output, 1 bit: at least one complete row is stored.
REQ-013 The block SHALL have port fin_fila, output, 1 bit: single-cycle pulse that coincides with the write of the last column.

Function
REQ-014 All outputs SHALL be registered; each accepted pixel SHALL appear on salida_x, escritura_x and direccion exactly 1 cycle after the edge where entrada_valida=1.
REQ-015 State machine states SHALL be LLENANDO_1 (write target is buffer 1) and LLENANDO_2 (write target is buffer 2); the reset state SHALL be LLENANDO_1.
REQ-016 The column counter SHALL advance by 1 only on an accepted pixel, and SHALL wrap from ANCHO_FILA-1 to 0.
REQ-017 On an accepted pixel at column ANCHO_FILA-1:
- the state SHALL toggle;
- seleccion SHALL become the buffer just completed;
- fin_fila SHALL pulse;
- fila_lista SHALL become 1.
REQ-018 Only the target buffer's write enable SHALL assert; escritura_1 and escritura_2 SHALL never be 1 in the same cycle.
REQ-019 Both salida_1 and salida_2 SHALL carry the registered pixel; the non-target output's value SHALL be don't-care.
REQ-020 With entrada_valida=0, both enables SHALL be 0, fin_fila SHALL be 0, and counter/state SHALL hold (stalls of any length, mid-row included).
REQ-021 seleccion SHALL change only on row completion, never mid-row.
REQ-022 fila_lista SHALL stay 1 until reset.

Reset
REQ-023 Assertion of reset_n=0 SHALL immediately force:
- state to LLENANDO_1;
- column counter to 0;
- escritura_1, escritura_2 and fin_fila to 0;
- fila_lista to 0;
- seleccion to 0;
- direccion to 0;
- salida_1 and salida_2 to 0.
REQ-024 Reset mid-row SHALL discard the partial row; the first accepted pixel after deassertion SHALL be written to buffer 1, column 0.

Configuration
REQ-025 With macro DEMUX_FILAS_CONTADOR_EN defined, the block SHALL add output conteo_filas (16 bits):
- reset value 0;
- increments on each fin_fila pulse;
- wraps 65535 to 0.
REQ-026 Without DEMUX_FILAS_CONTADOR_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package demux_filas_pkg SHALL hold the state encodings LLENANDO_1=0 and LLENANDO_2=1, and the default constants for BITS_DATOS, ANCHO_FILA and BITS_DIR.
REQ-028 The column counter SHALL be a sub-module contador_columnas with these ports:
- inputs: clk, reset_n, habilitar;
- outputs: cuenta, ultimo.

Verification (ANCHO_FILA=4, BITS_DATOS=8)
REQ-029 Stream pixels 0x10..0x13 with entrada_valida continuously 1:
- escritura_1 asserts with direccion 0,1,2,3;
- fin_fila pulses with direccion=3;
- then seleccion=0 and fila_lista=1.
REQ-030 Stream 8 further pixels 0x20..0x27:
- 0x20..0x23 go to buffer 2, then seleccion=1;
- 0x24..0x27 go to buffer 1, then seleccion=0;
- escritura_1 and escritura_2 are never both 1.
REQ-031 Insert 3 idle cycles after column 1: direccion and state hold, no enables assert, and the row completes normally after 4 accepted pixels.
REQ-032 Pulse reset_n low asynchronously after column 2 of row 2: all outputs go to 0 at once, and the next pixel 0x55 is written to buffer 1, column 0.
REQ-033 With DEMUX_FILAS_CONTADOR_EN defined, stream 3 rows: conteo_filas=3. Force the count to 65535 and complete one more row: conteo_filas=0.
REQ-034 Build without the macro: the port list has no conteo_filas, and REQ-029..REQ-032 pass unchanged.

Source files
------------

// File: rtl/demux_filas_pkg.sv
// Shared definitions for the 1:2 row demultiplexer: state encodings and default sizes.
package demux_filas_pkg;

  typedef enum logic {
    LLENANDO_1 = 1'b0,
    LLENANDO_2 = 1'b1
  } estado_t;

  localparam int BITS_DATOS_DEF = 8;
  localparam int ANCHO_FILA_DEF = 640;
  localparam int BITS_DIR_DEF   = 10;

endpackage

// File: rtl/demux_1_2_filas_contador.sv
// Column counter: advances on each accepted pixel and wraps after the last column of a row.
module contador_columnas #(
  parameter int ANCHO_FILA = 640,
  parameter int BITS_DIR   = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                habilitar,
  output logic [BITS_DIR-1:0] cuenta,
  output logic                ultimo
);

  localparam logic [BITS_DIR-1:0] COL_FINAL = BITS_DIR'(ANCHO_FILA - 1);

  assign ultimo = (cuenta == COL_FINAL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cuenta <= '0;
    end else if (habilitar) begin
      cuenta <= ultimo ? '0 : cuenta + 1'b1;
    end
  end

endmodule

// File: rtl/demux_1_2_filas.sv
// Steers an incoming pixel stream alternately into two row buffers, one full row each.
// Optional DEMUX_FILAS_CONTADOR_EN adds a 16-bit completed-row counter (conteo_filas).
//
// state      | meaning
// LLENANDO_1 | pixels are written to row buffer 1
// LLENANDO_2 | pixels are written to row buffer 2
module demux_1_2_filas
  import demux_filas_pkg::*;
#(
  parameter int BITS_DATOS = BITS_DATOS_DEF,
  parameter int ANCHO_FILA = ANCHO_FILA_DEF,
  parameter int BITS_DIR   = BITS_DIR_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [BITS_DATOS-1:0] entrada,
  input  logic                  entrada_valida,
  output logic [BITS_DATOS-1:0] salida_1,
  output logic [BITS_DATOS-1:0] salida_2,
  output logic                  escritura_1,
  output logic                  escritura_2,
  output logic [BITS_DIR-1:0]   direccion,
  output logic                  seleccion,
  output logic                  fila_lista,
  output logic                  fin_fila
`ifdef DEMUX_FILAS_CONTADOR_EN
  ,
  output logic [15:0]           conteo_filas
`endif
);

  estado_t               estado, estado_sig;
  logic [BITS_DIR-1:0]   cuenta;
  logic                  ultimo;
  logic [BITS_DATOS-1:0] dato_q;
  logic                  cierre_fila;

  assign cierre_fila = entrada_valida & ultimo;

  contador_columnas #(
    .ANCHO_FILA(ANCHO_FILA),
    .BITS_DIR  (BITS_DIR)
  ) u_contador (
    .clk      (clk),
    .reset_n  (reset_n),
    .habilitar(entrada_valida),
    .cuenta   (cuenta),
    .ultimo   (ultimo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado <= LLENANDO_1;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    if (cierre_fila) begin
      estado_sig = (estado == LLENANDO_1) ? LLENANDO_2 : LLENANDO_1;
    end
  end

  // Both data outputs share one register; only the enabled buffer consumes it.
  assign salida_1 = dato_q;
  assign salida_2 = dato_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dato_q      <= '0;
      escritura_1 <= 1'b0;
      escritura_2 <= 1'b0;
      direccion   <= '0;
      fin_fila    <= 1'b0;
      seleccion   <= 1'b0;
      fila_lista  <= 1'b0;
    end else begin
      escritura_1 <= entrada_valida & (estado == LLENANDO_1);
      escritura_2 <= entrada_valida & (estado == LLENANDO_2);
      fin_fila    <= cierre_fila;
      if (entrada_valida) begin
        dato_q    <= entrada;
        direccion <= cuenta;
      end
      if (cierre_fila) begin
        seleccion  <= (estado == LLENANDO_2);
        fila_lista <= 1'b1;
      end
    end
  end

`ifdef DEMUX_FILAS_CONTADOR_EN
  // Updated on the same edge that raises fin_fila, so both become visible together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conteo_filas <= '0;
    end else if (cierre_fila) begin
      conteo_filas <= conteo_filas + 16'd1;
    end
  end
`endif

endmodule
